// File: rtl/adc_capture_sched.sv
// Capture scheduler: filters ADC responses by channel, buffers them in a small FIFO and
// shares the single-port sample RAM between ring-buffer writes and a priority readout port.
module adc_capture_sched #(
    parameter int AW         = 3,
    parameter int DW         = 12,
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 2,
    parameter int RD_LAT     = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          oneshot,
    input  logic          adc_valid,
    input  logic [4:0]    adc_channel,
    input  logic [DW-1:0] adc_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic [AW-1:0] wr_ptr,
    output logic [AW:0]   sample_count,
    output logic          overflow,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [4:0]  CH_SEL  = 5'(CHANNEL);

    state_t          state_r;
    state_t          state_s;
    logic            oneshot_r;
    logic [DW-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   fifo_cnt_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW:0]     sample_count_r;
    logic            overflow_r;
    logic [RD_LAT-1:0] rd_pipe_r;
    logic [DW-1:0]   rd_hold_r;

    logic            full_s;
    logic            empty_s;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            cnt_inc_s;
    logic            rd_ack_s;
    logic            ram_wren_s;
    logic [AW-1:0]   ram_address_s;
    logic [DW-1:0]   ram_data_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            ptr_next = {PW{1'b0}};
        end else begin
            ptr_next = p + PW'(1);
        end
    endfunction

    assign full_s  = (fifo_cnt_r == CW'(FIFO_DEPTH));
    assign empty_s = (fifo_cnt_r == {CW{1'b0}});

    // RAM port arbitration: readout has strict priority over draining the FIFO
    always_comb begin
        rd_ack_s      = 1'b0;
        ram_wren_s    = 1'b0;
        ram_address_s = {AW{1'b0}};
        ram_data_s    = {DW{1'b0}};
        pop_s         = 1'b0;
        if (rd_req && !rst) begin
            rd_ack_s      = 1'b1;
            ram_address_s = rd_addr;
        end else if (!empty_s) begin
            ram_wren_s    = 1'b1;
            ram_address_s = wr_ptr_r;
            ram_data_s    = fifo_mem_r[head_r];
            pop_s         = 1'b1;
        end else begin
            pop_s         = 1'b0;
        end
    end

    // Sample acceptance; a full FIFO still takes a sample when it pops on the same edge
    always_comb begin
        accept_s  = (state_r == ST_CAPTURE) && adc_valid && (adc_channel == CH_SEL);
        push_s    = accept_s && (!full_s || pop_s);
        cnt_inc_s = push_s && (sample_count_r != CNT_MAX);
    end

    // Next-state logic; start overrides everything including stop
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_CAPTURE;
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    if (stop) begin
                        state_s = ST_IDLE;
                    end else if (oneshot_r && cnt_inc_s &&
                                 (sample_count_r == CNT_MAX - (AW+1)'(1))) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_IDLE:  state_s = ST_IDLE;
                ST_DONE:  state_s = ST_DONE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State register and mode latch
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            oneshot_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start) begin
                oneshot_r <= oneshot;
            end
        end
    end

    // FIFO, ring write pointer and capture statistics
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {DW{1'b0}};
            end
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            fifo_cnt_r     <= {CW{1'b0}};
            wr_ptr_r       <= {AW{1'b0}};
            sample_count_r <= {(AW+1){1'b0}};
            overflow_r     <= 1'b0;
        end else if (start) begin
            head_r         <= {PW{1'b0}};
            tail_r         <= {PW{1'b0}};
            fifo_cnt_r     <= {CW{1'b0}};
            wr_ptr_r       <= {AW{1'b0}};
            sample_count_r <= {(AW+1){1'b0}};
            overflow_r     <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[tail_r] <= adc_data;
                tail_r             <= ptr_next(tail_r);
            end
            if (pop_s) begin
                head_r   <= ptr_next(head_r);
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (cnt_inc_s) begin
                sample_count_r <= sample_count_r + (AW+1)'(1);
            end
            if (accept_s && !push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Read-latency pipeline and rd_data hold register (unaffected by start)
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rd_pipe_r <= {RD_LAT{1'b0}};
            rd_hold_r <= {DW{1'b0}};
        end else begin
            rd_pipe_r <= (rd_pipe_r << 1) | RD_LAT'(rd_ack_s);
            if (rd_pipe_r[RD_LAT-1]) begin
                rd_hold_r <= ram_q;
            end
        end
    end

    assign rd_ack       = rd_ack_s;
    assign rd_valid     = rd_pipe_r[RD_LAT-1];
    assign rd_data      = rd_pipe_r[RD_LAT-1] ? ram_q : rd_hold_r;
    assign ram_address  = ram_address_s;
    assign ram_data     = ram_data_s;
    assign ram_wren     = ram_wren_s;
    assign wr_ptr       = wr_ptr_r;
    assign sample_count = sample_count_r;
    assign overflow     = overflow_r;
    assign state        = state_r;

endmodule

// File: doc/adc_capture_sched.md
Name: adc_capture_sched

Overview:
- Capture scheduler between the ADC sequencer response stream and the single-port sample RAM.
- Filters ADC responses by channel and buffers accepted samples in a small FIFO.
- Arbitrates the one RAM port between ring-buffer sample writes and an external readout requester, such as the display or LED logic.
- Supports continuous (wrapping) and one-shot capture modes.

Parameters:
AW, 3, RAM address width; ring depth = 2^AW
DW, 12, sample/RAM data width
CHANNEL, 0, only ADC responses with this channel number are captured
FIFO_DEPTH, 2, pending-sample buffer entries (>=1)
RD_LAT, 2, cycles from read grant edge to valid ram_q

Ports:
clk_in  in  1  sole clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: restart capture
stop  in  1  pulse: end capture
oneshot  in  1  mode, sampled only on start (1 = stop after 2^AW samples)
adc_valid  in  1  ADC response valid (no backpressure)
adc_channel  in  5  ADC response channel
adc_data  in  DW  ADC response data
rd_req  in  1  readout request, held until rd_ack
rd_addr  in  AW  readout address, stable while rd_req
rd_ack  out  1  read granted this cycle
rd_valid  out  1  rd_data valid pulse
rd_data  out  DW  read result
ram_address  out  AW  RAM address
ram_data  out  DW  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DW  RAM read data
wr_ptr  out  AW  next write address
sample_count  out  AW+1  accepted samples since start, saturating at 2^AW
overflow  out  1  sticky: a sample was dropped
state  out  2  0 IDLE, 1 CAPTURE, 2 DONE

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, read pipeline cleared. Reset mid-operation discards pending samples and in-flight reads; no rd_valid follows.
- FSM:
  - start in any state -> CAPTURE; clears wr_ptr, sample_count, overflow and FIFO; latches oneshot. In-flight reads are unaffected.
  - stop in CAPTURE -> IDLE. start and stop in the same cycle: start wins.
  - CAPTURE with oneshot latched: the edge on which sample_count reaches 2^AW -> DONE.
  - DONE and IDLE are left only by start.
  - The FIFO keeps draining to RAM in IDLE and DONE.
- Accept rule: state == CAPTURE && adc_valid && adc_channel == CHANNEL.
  - Accepted sample is pushed if the FIFO is not full, or if it pops in the same cycle; sample_count increments (saturating).
  - Otherwise the sample is dropped, overflow <= 1 and sample_count is unchanged.
  - Non-matching channels are ignored silently.
- Arbitration, one RAM op per cycle, combinational grant:
  - rd_req has strict priority; the write is granted only when rd_req = 0 and the FIFO is non-empty.
  - Read grant: rd_ack = 1, ram_address = rd_addr, ram_wren = 0.
  - Write grant: ram_wren = 1, ram_address = wr_ptr, ram_data = FIFO head. Pop at the edge; wr_ptr <= wr_ptr+1 mod 2^AW (wraps in continuous mode).
  - No grant: ram_wren = 0, ram_address = 0, ram_data = 0.
- Latency:
  - A sample accepted at edge N is written at the earliest in the cycle after N.
  - rd_valid pulses for one cycle RD_LAT cycles after the rd_ack cycle's edge, with rd_data = ram_q in that cycle. rd_data holds until the next rd_valid.
  - Back-to-back reads are pipelined: one grant per cycle.

Test Plan:
- Reset, start (oneshot = 0); ch0 samples 0x111, 0x222, 0x333 on consecutive cycles, no reads -> ram_wren at addresses 0, 1, 2 with those data, each one cycle after its accept; wr_ptr = 3, sample_count = 3, overflow = 0.
- Sample ch5 = 0xABC during CAPTURE, then ch0 samples while in IDLE -> no write, sample_count unchanged.
- rd_req held 5 cycles (rd_addr = 1) while ch0 samples 0xA01..0xA04 arrive every cycle -> 5 read grants; 3rd and 4th samples dropped; overflow = 1. After rd_req drops, 0xA01 and 0xA02 are written to addresses 0 and 1; rd_valid pulses 2 cycles after each ack.
- oneshot = 1, AW = 3, 9 ch0 samples -> state = DONE after the 8th; 9th ignored; sample_count = 8; wr_ptr = 0 after drain.
- Continuous mode, 10 samples -> addresses 0..7, then 0 and 1 overwritten; sample_count = 8 (saturated); wr_ptr = 2.
- Assert rst one cycle after a read grant, with 2 samples pending -> no rd_valid, no further ram_wren; all outputs 0; state = IDLE.
